// File: rtl/riscv_pkg.sv
// Shared constants for the RV32I+M execute stage: ALU op classes, funct codes
// and the iterative multiplier state encoding.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_BR  = 2'b01;
    localparam logic [1:0] ALU_R   = 2'b10;
    localparam logic [1:0] ALU_I   = 2'b11;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;

    localparam logic [6:0] FUNCT7_SUB    = 7'b0100000;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DONE = 2'b10
    } mul_state_t;

endpackage

// File: rtl/mul_iter.sv
// Iterative 32x32 multiplier: 32 shift-add steps on operand magnitudes,
// sign correction and half select applied once the product is complete.
module mul_iter
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            kill,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      funct3,
    output logic            busy,
    output logic            ready,
    output logic [XLEN-1:0] product
);

    mul_state_t        state, state_next;
    logic [4:0]        count;
    logic [XLEN-1:0]   mcand;
    logic [2*XLEN-1:0] acc;
    logic              neg;
    logic              hi_sel;
    logic              a_signed, b_signed;
    logic [XLEN:0]     step_sum;
    logic [2*XLEN-1:0] corrected;

    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] x, input logic sgn);
        return (sgn && x[XLEN-1]) ? -x : x;
    endfunction

    function automatic logic [2*XLEN-1:0] sign_fix(input logic [2*XLEN-1:0] p, input logic n);
        return n ? -p : p;
    endfunction

    assign a_signed = (funct3 == F3_MULH) || (funct3 == F3_MULHSU);
    assign b_signed = (funct3 == F3_MULH);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start && !kill) state_next = S_MUL;
            S_MUL: begin
                if (kill)               state_next = S_IDLE;
                else if (count == 5'd31) state_next = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            if (state == S_IDLE)
                count <= '0;
            else if (state == S_MUL)
                count <= count + 5'd1;
        end
    end

    // Low half of acc starts as the multiplier and is shifted out one bit per step.
    assign step_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);

    always_ff @(posedge clk) begin
        if (state == S_IDLE && start && !kill) begin
            mcand  <= magnitude(a, a_signed);
            acc    <= {{XLEN{1'b0}}, magnitude(b, b_signed)};
            neg    <= (a_signed & a[XLEN-1]) ^ (b_signed & b[XLEN-1]);
            hi_sel <= (funct3 != F3_MUL);
        end else if (state == S_MUL) begin
            acc <= {step_sum, acc[XLEN-1:1]};
        end
    end

    assign corrected = sign_fix(acc, neg);
    assign product   = hi_sel ? corrected[2*XLEN-1:XLEN] : corrected[XLEN-1:0];
    assign busy      = (state == S_MUL);
    assign ready     = (state == S_DONE);

endmodule

// File: rtl/ex_stage.sv
// Execute stage with operand forwarding, ALU, iterative multiply stall
// control and the EX/MEM pipeline register.
module ex_stage
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    input  logic [XLEN-1:0] rd1,
    input  logic [XLEN-1:0] rd2,
    input  logic [XLEN-1:0] imm,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [4:0]      rd,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [1:0]      alu_op,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic            mem_to_reg,
    input  logic            alu_src,
    input  logic            reg_write,
    input  logic            flush,
    input  logic [4:0]      memwb_rd,
    input  logic            memwb_reg_write,
    input  logic [XLEN-1:0] memwb_data,
    output logic            stall,
    output logic            exmem_valid,
    output logic [XLEN-1:0] exmem_alu_result,
    output logic [XLEN-1:0] exmem_store_data,
    output logic [4:0]      exmem_rd,
    output logic            exmem_zero,
    output logic            exmem_mem_read,
    output logic            exmem_mem_write,
    output logic            exmem_mem_to_reg,
    output logic            exmem_reg_write
);

    logic [XLEN-1:0]        fwd_a, fwd_b, op2;
    logic signed [XLEN-1:0] a_s, op2_s;
    logic [4:0]             shamt;
    logic                   alt_op;
    logic [XLEN-1:0]        alu_res, ex_result;
    logic                   is_mul, mul_start, mul_busy, mul_ready;
    logic [XLEN-1:0]        mul_product;

    // EX/MEM has priority because it holds the younger producer.
    always_comb begin
        fwd_a = rd1;
        if (exmem_valid && exmem_reg_write && exmem_rd == rs1 && rs1 != 5'd0)
            fwd_a = exmem_alu_result;
        else if (memwb_reg_write && memwb_rd == rs1 && rs1 != 5'd0)
            fwd_a = memwb_data;

        fwd_b = rd2;
        if (exmem_valid && exmem_reg_write && exmem_rd == rs2 && rs2 != 5'd0)
            fwd_b = exmem_alu_result;
        else if (memwb_reg_write && memwb_rd == rs2 && rs2 != 5'd0)
            fwd_b = memwb_data;
    end

    assign op2   = alu_src ? imm : fwd_b;
    assign a_s   = fwd_a;
    assign op2_s = op2;
    assign shamt = op2[4:0];

    always_comb begin
        alt_op  = (alu_op == ALU_R) ? (funct7 == FUNCT7_SUB) : funct7[5];
        alu_res = '0;
        case (alu_op)
            ALU_ADD: alu_res = fwd_a + op2;
            ALU_BR:  alu_res = fwd_a - fwd_b;
            default: begin
                case (funct3)
                    F3_ADD:  alu_res = (alu_op == ALU_R && alt_op) ? fwd_a - op2 : fwd_a + op2;
                    F3_SLL:  alu_res = fwd_a << shamt;
                    F3_SLT:  alu_res = {{(XLEN-1){1'b0}}, a_s < op2_s};
                    F3_SLTU: alu_res = {{(XLEN-1){1'b0}}, fwd_a < op2};
                    F3_XOR:  alu_res = fwd_a ^ op2;
                    F3_SR:   alu_res = alt_op ? XLEN'(a_s >>> shamt) : fwd_a >> shamt;
                    F3_OR:   alu_res = fwd_a | op2;
                    default: alu_res = fwd_a & op2;
                endcase
            end
        endcase
    end

    assign is_mul    = (alu_op == ALU_R) && (funct7 == FUNCT7_MULDIV);
    // No stall request while reset is held, whatever sits in ID/EX.
    assign mul_start = reset_n & in_valid & is_mul & ~flush & ~mul_busy & ~mul_ready;
    assign stall     = mul_start | mul_busy;

    mul_iter u_mul_iter (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (mul_start),
        .kill    (flush),
        .a       (fwd_a),
        .b       (fwd_b),
        .funct3  (funct3),
        .busy    (mul_busy),
        .ready   (mul_ready),
        .product (mul_product)
    );

    // A multiply only reaches this point unstalled when the product is ready.
    assign ex_result = is_mul ? mul_product : alu_res;

    // EX/MEM boundary
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exmem_valid      <= 1'b0;
            exmem_alu_result <= '0;
            exmem_store_data <= '0;
            exmem_rd         <= '0;
            exmem_zero       <= 1'b0;
            exmem_mem_read   <= 1'b0;
            exmem_mem_write  <= 1'b0;
            exmem_mem_to_reg <= 1'b0;
            exmem_reg_write  <= 1'b0;
        end else if (flush || stall || !in_valid) begin
            exmem_valid      <= 1'b0;
            exmem_mem_read   <= 1'b0;
            exmem_mem_write  <= 1'b0;
            exmem_mem_to_reg <= 1'b0;
            exmem_reg_write  <= 1'b0;
        end else begin
            exmem_valid      <= 1'b1;
            exmem_alu_result <= ex_result;
            exmem_store_data <= fwd_b;
            exmem_rd         <= rd;
            exmem_zero       <= (ex_result == '0);
            exmem_mem_read   <= mem_read;
            exmem_mem_write  <= mem_write;
            exmem_mem_to_reg <= mem_to_reg;
            exmem_reg_write  <= reg_write;
        end
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage RV32I(+M multiply) pipeline, including the EX/MEM pipeline register. It sits directly downstream of the ID/EX register and takes its decoded operands and control bits. It resolves RAW hazards by forwarding from EX/MEM and MEM/WB, computes ALU results, and runs MUL/MULH/MULHSU/MULHU on an iterative multiplier that stalls the front of the pipe. Load-use hazards are handled upstream; this block never sees a load result in EX/MEM.

## Interface
- XLEN, 32, datapath width (only 32 supported)
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  ID/EX holds a real instruction (0 = bubble)
- rd1, rd2, imm  in  32 each  register operands, sign-extended immediate
- rs1, rs2, rd  in  5 each  register indices
- funct3  in  3;  funct7  in  7;  alu_op  in  2
- mem_read, mem_write, mem_to_reg, alu_src, reg_write  in  1 each  control from ID/EX
- flush  in  1  kill the instruction in EX and any multiply in flight
- memwb_rd  in  5;  memwb_reg_write  in  1;  memwb_data  in  32  MEM/WB writeback path
- stall  out  1  freeze PC, IF/ID and ID/EX (combinational)
- exmem_valid, exmem_alu_result(32), exmem_store_data(32), exmem_rd(5), exmem_zero, exmem_mem_read, exmem_mem_write, exmem_mem_to_reg, exmem_reg_write  out  registered EX/MEM fields

## Operation
- Forwarding, per operand (rs1 -> A, rs2 -> B):
  - EX/MEM hit first: exmem_valid & exmem_reg_write & exmem_rd==rs & rs!=0 -> exmem_alu_result.
  - Else MEM/WB hit: memwb_reg_write & memwb_rd==rs & rs!=0 -> memwb_data.
  - Else the register value.
- Second ALU operand = alu_src ? imm : B. store_data = forwarded B.
- alu_op decode:
  - 00: A+op2 (load/store address).
  - 01: A-B (branch compare); zero = (A-B==0).
  - 10: R-type by funct3/funct7. funct7=0100000 selects SUB/SRA. funct7=0000001 is multiply.
  - 11: I-type by funct3. SRAI when funct7[5]=1.
- Shifts use op2[4:0]. SLT is signed, SLTU unsigned. zero flag is computed for every op.
- Multiplier FSM, states IDLE -> MUL -> DONE -> IDLE:
  - IDLE: on in_valid & mul & !flush, capture forwarded A, B and funct3, and go to MUL with count=0. Operands must be captured here because EX/MEM drains during the stall.
  - MUL: 32 iterations of unsigned shift-add on operand magnitudes into a 64-bit accumulator. Signed handling per funct3: 000 MUL low 32; 001 MULH s×s; 010 MULHSU s×u; 011 MULHU u×u. Count reaches 31 -> DONE.
  - DONE: apply sign correction (two's-complement negate of the 64-bit product when signs differ), select the half, load EX/MEM, return to IDLE.
- While stall is high, EX/MEM loads a bubble: exmem_valid=0 and all control outputs 0.
- flush: EX/MEM loads a bubble and the FSM returns to IDLE, dropping the product. flush takes priority over everything.
- Bubble input (in_valid=0) loads exmem_valid=0 with all control outputs 0.

## Timing
- Reset (reset_n=0, async): every exmem_* output 0, FSM IDLE, count 0, stall 0.
- Non-multiply: result at EX/MEM outputs one edge after presentation.
- Multiply arriving in cycle 0:
  - stall=1 in cycles 0..32.
  - DONE is cycle 33, with stall=0 and ID/EX still holding the MUL.
  - Result visible after the edge ending cycle 33.
  - Total 34 cycles.
- stall = (IDLE & in_valid & mul & !flush) | MUL. stall is 0 in DONE so ID/EX advances at that same edge.
- A multiply followed back-to-back by another multiply starts the next operation from IDLE in cycle 34.
- flush and a multiply start in the same cycle: no start, stall=0.
- reset_n asserted mid-multiply: FSM goes to IDLE immediately and the partial product is discarded.

## Structure
- Package riscv_pkg holds:
  - alu_op codes ALU_ADD=00, ALU_BR=01, ALU_R=10, ALU_I=11.
  - funct3 constants for ALU and M operations.
  - FUNCT7_SUB=0100000, FUNCT7_MULDIV=0000001.
  - FSM state enum.
- One sub-module, mul_iter, contains the FSM, counter and 64-bit accumulator. Its interface is start/ready, a, b, funct3 in, and product out. Forwarding, ALU and the EX/MEM register live in ex_stage.

## Test plan
- Reset: reset_n=0 mid-stream -> all exmem_* outputs 0 and stall 0 asynchronously. After release, ADD 5+7 -> exmem_alu_result=12 one edge later.
- Forwarding priority: ADD x1=3 followed by SUB x2=x1-x1 while MEM/WB also writes x1=99 -> EX/MEM value used, result 0, exmem_zero=1. Same case with rd=x0 -> no forward.
- I-type: SRAI with rd1=0x80000000, imm shamt 4 -> 0xF8000000. SLTIU with rd1=1, imm=-1 -> 1.
- MULH: 0xFFFFFFFE × 0x00000003 -> 0xFFFFFFFF, with stall high exactly cycles 0..32 and the result after the cycle-33 edge. MULHU on the same operands -> 0x00000002. MUL low -> 0xFFFFFFFA.
- Flush at multiply cycle 10 -> stall drops next cycle, exmem_valid=0, and no result is written.
- Store path: SW with forwarded rs2 from MEM/WB=0xDEADBEEF -> exmem_store_data=0xDEADBEEF and exmem_mem_write=1.
